// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, field limits,
// the default tick rate and the digit/limit helper functions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Encoding of SW[9:8]
  typedef enum logic [1:0] {
    FIELD_SEC  = 2'b00,
    FIELD_MIN  = 2'b01,
    FIELD_HOUR = 2'b10,
    FIELD_NONE = 2'b11
  } field_t;

  localparam logic [5:0] SEC_MAX        = 6'd59;
  localparam logic [5:0] MIN_MAX        = 6'd59;
  localparam logic [5:0] HOUR_MAX       = 6'd23;
  localparam int         CLK_HZ_DEFAULT = 50_000_000;

  // Clamp a loaded value to the field's upper limit.
  function automatic logic [5:0] sat_limit(input logic [5:0] value,
                                           input logic [5:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

endpackage

// File: rtl/timer_bcd_digit.sv
// Splits a 0-59 binary value into tens/ones digits and drives two
// active-low seven-segment patterns, tens digit first.
module timer_bcd_digit
  import timer_pkg::*;
(
  input  logic [5:0] value,
  output logic [6:0] tens,
  output logic [6:0] ones
);

  logic [3:0] tens_digit;
  logic [3:0] ones_digit;

  // Decimal split and segment lookup, purely combinational.
  always_comb begin
    tens_digit = 4'(value / 6'd10);
    ones_digit = 4'(value % 6'd10);
    tens       = seg7(tens_digit);
    ones       = seg7(ones_digit);
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with load/start pushbuttons, a one-second
// prescaler and a six-digit active-low seven-segment display.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       done
);

  localparam int             PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);

  logic [1:0]    key_s1, key_s2, key_prev;
  logic          start_press, load_press;
  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [4:0]    hours;
  logic [5:0]    minutes, seconds;
  logic          time_zero, at_one_sec;
  logic          do_load, clr_presc, presc_en, tick;
  field_t        field;
  logic          unused_sw;

  assign field     = field_t'(SW[9:8]);
  assign unused_sw = ^SW[7:6];

  // Two-flop synchronizer plus edge history; idles at 1 (buttons released).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      key_s1   <= 2'b11;
      key_s2   <= 2'b11;
      key_prev <= 2'b11;
    end else begin
      key_s1   <= KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  assign start_press = key_prev[0] & ~key_s2[0];
  assign load_press  = key_prev[1] & ~key_s2[1];

  assign time_zero  = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd0);
  assign at_one_sec = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath controls; start always wins over load.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_next = state;
    do_load    = 1'b0;
    clr_presc  = 1'b0;
    presc_en   = 1'b0;
    tick       = 1'b0;
    case (state)
      IDLE: begin
        if (start_press) begin
          if (!time_zero) begin
            state_next = RUN;
            clr_presc  = 1'b1;
          end
        end else if (load_press) begin
          do_load   = 1'b1;
          clr_presc = 1'b1;
        end
      end
      PAUSE: begin
        // Resuming keeps the partial second accumulated before the pause.
        if (start_press) begin
          if (!time_zero) state_next = RUN;
        end else if (load_press) begin
          do_load   = 1'b1;
          clr_presc = 1'b1;
        end
      end
      RUN: begin
        if (start_press) begin
          state_next = PAUSE;
        end else begin
          presc_en = 1'b1;
          if (presc == PRESC_LAST) begin
            tick = 1'b1;
            if (at_one_sec) state_next = EXPIRED;
          end
        end
      end
      EXPIRED: begin
        if (start_press) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler: frozen outside RUN, cleared on start-from-idle and on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (clr_presc) begin
      presc <= '0;
    end else if (presc_en) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Time registers: saturating field loads, borrow-chained decrement on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours   <= 5'd0;
      minutes <= 6'd0;
      seconds <= 6'd0;
    end else if (do_load) begin
      case (field)
        FIELD_SEC:  seconds <= sat_limit(SW[5:0], SEC_MAX);
        FIELD_MIN:  minutes <= sat_limit(SW[5:0], MIN_MAX);
        FIELD_HOUR: hours   <= 5'(sat_limit(SW[5:0], HOUR_MAX));
        default:    ;
      endcase
    end else if (tick) begin
      // Time is never zero in RUN, so the hours borrow cannot underflow.
      if (seconds != 6'd0) begin
        seconds <= seconds - 6'd1;
      end else begin
        seconds <= SEC_MAX;
        if (minutes != 6'd0) begin
          minutes <= minutes - 6'd1;
        end else begin
          minutes <= MIN_MAX;
          hours   <= hours - 5'd1;
        end
      end
    end
  end

  assign done = (state == EXPIRED);

  timer_bcd_digit u_sec (.value(seconds),          .tens(HEX1), .ones(HEX0));
  timer_bcd_digit u_min (.value(minutes),          .tens(HEX3), .ones(HEX2));
  timer_bcd_digit u_hr  (.value({1'b0, hours}),    .tens(HEX5), .ones(HEX4));

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at CLK_HZ=4: stimulus queues the
// expected display/state for a given cycle, a monitor compares at negedge.
module tb_countdown_timer;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] SW = '0;
  logic [1:0] KEY = 2'b11;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       done;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    string       name;
    logic [41:0] hex;
    logic        done;
    state_t      st;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .SW(SW), .KEY(KEY),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int h, input int m, input int s);
    return {pat(h / 10), pat(h % 10), pat(m / 10), pat(m % 10), pat(s / 10), pat(s % 10)};
  endfunction

  task automatic check(input string name, input logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s @cyc %0d", name, cyc);
    end
  endtask

  task automatic expect_at(input int k, input string name, input int h,
                           input int m, input int s, input state_t st);
    exp_t e;
    e.due  = cyc + k;
    e.name = name;
    e.hex  = disp(h, m, s);
    e.done = (st == EXPIRED);
    e.st   = st;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the buttons low across the synchronizer; acts on the 4th edge.
  task automatic press(input logic [1:0] mask);
    @(posedge clk);
    #1 KEY = ~mask;
    repeat (3) @(posedge clk);
    #1 KEY = 2'b11;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compare every entry whose cycle has come.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        logic [41:0] act;
        e   = sb.pop_front();
        act = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        if (e.due != cyc || act !== e.hex || done !== e.done || dut.state !== e.st)
          $display("  %s: hex=%h done=%b state=%0d, expected hex=%h done=%b state=%0d (due %0d)",
                   e.name, act, done, dut.state, e.hex, e.done, e.st, e.due);
        check(e.name, e.due == cyc && act === e.hex && done === e.done && dut.state === e.st);
      end
    end
  end

  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;

  initial begin
    // Reset state and start at zero.
    do_reset();
    check("reset_done_low", done === 1'b0);
    check("reset_hex0_zero", HEX0 === 7'b1000000);
    check("reset_hex5_zero", HEX5 === 7'b1000000);
    check("reset_state_idle", dut.state === IDLE);
    expect_at(0, "reset", 0, 0, 0, IDLE);
    press(START);
    expect_at(0, "start_at_zero", 0, 0, 0, IDLE);

    // Saturating loads, no-field select, reset mid-RUN.
    SW = {2'b10, 2'b00, 6'd40}; press(LOAD);
    check("hours_sat_hex5", HEX5 === 7'b0100100);
    check("hours_sat_hex4", HEX4 === 7'b0110000);
    expect_at(0, "hours_sat_23", 23, 0, 0, IDLE);
    SW = {2'b00, 2'b00, 6'd63}; press(LOAD);
    expect_at(0, "sec_sat_59", 23, 0, 59, IDLE);
    SW = {2'b11, 2'b00, 6'd12}; press(LOAD);
    expect_at(0, "no_field", 23, 0, 59, IDLE);
    press(START);
    expect_at(0, "run_23h", 23, 0, 59, RUN);
    step(2);
    do_reset();
    expect_at(0, "reset_mid_run", 0, 0, 0, IDLE);

    // Load 00:01:02, run 8 clk, pause at prescaler 2, resume.
    SW = {2'b00, 2'b00, 6'd2}; press(LOAD);
    SW = {2'b01, 2'b00, 6'd1}; press(LOAD);
    expect_at(0, "load_0102", 0, 1, 2, IDLE);
    press(START);
    expect_at(0, "run_enter", 0, 1, 2, RUN);
    expect_at(3, "pre_tick", 0, 1, 2, RUN);
    expect_at(4, "tick1", 0, 1, 1, RUN);
    expect_at(8, "after_8clk", 0, 1, 0, RUN);
    step(7);
    press(START);
    expect_at(0, "pause_enter", 0, 1, 0, PAUSE);
    expect_at(50, "pause_hold50", 0, 1, 0, PAUSE);
    expect_at(100, "pause_hold100", 0, 1, 0, PAUSE);
    step(100);
    press(START);
    expect_at(0, "resume", 0, 1, 0, RUN);
    expect_at(1, "resume_hold", 0, 1, 0, RUN);
    expect_at(2, "resume_tick", 0, 0, 59, RUN);
    step(2);

    // Pause, load 5 s, then simultaneous load+start: start wins.
    press(START);
    expect_at(0, "pause2", 0, 0, 59, PAUSE);
    SW = {2'b00, 2'b00, 6'd5}; press(LOAD);
    expect_at(0, "load_in_pause", 0, 0, 5, PAUSE);
    SW = {2'b00, 2'b00, 6'd30}; press(START | LOAD);
    expect_at(0, "simul_press", 0, 0, 5, RUN);
    expect_at(3, "simul_hold", 0, 0, 5, RUN);
    expect_at(4, "simul_tick", 0, 0, 4, RUN);
    expect_at(19, "last_second", 0, 0, 1, RUN);
    expect_at(20, "expired", 0, 0, 0, EXPIRED);
    step(20);
    SW = {2'b10, 2'b00, 6'd5}; press(LOAD);
    expect_at(0, "load_in_expired", 0, 0, 0, EXPIRED);
    press(START);
    expect_at(0, "ack_to_idle", 0, 0, 0, IDLE);

    // One hour countdown with borrow, load ignored while running.
    SW = {2'b10, 2'b00, 6'd1}; press(LOAD);
    expect_at(0, "load_1h", 1, 0, 0, IDLE);
    press(START);
    expect_at(0, "run_1h", 1, 0, 0, RUN);
    expect_at(4, "borrow_hour", 0, 59, 59, RUN);
    expect_at(8, "borrow_tick2", 0, 59, 58, RUN);
    expect_at(240, "min_boundary", 0, 59, 0, RUN);
    expect_at(244, "borrow_min", 0, 58, 59, RUN);
    expect_at(14399, "hour_last_sec", 0, 0, 1, RUN);
    expect_at(14400, "hour_expired", 0, 0, 0, EXPIRED);
    SW = {2'b00, 2'b00, 6'd7}; press(LOAD);
    step(14396);

    // Reset during EXPIRED, then start at zero.
    do_reset();
    check("reset_expired_done_low", done === 1'b0);
    check("reset_expired_hex3_zero", HEX3 === 7'b1000000);
    expect_at(0, "reset_expired", 0, 0, 0, IDLE);
    press(START);
    expect_at(0, "start_zero_after_reset", 0, 0, 0, IDLE);

    step(5);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never checked, due %0d now %0d", e.name, e.due, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
